// File: rtl/wb_pipelined_slave_pkg.sv
// Shared constants and helpers for the pipelined Wishbone register-file slave.
package wb_pipelined_slave_pkg;

  localparam logic WB_WE_READ  = 1'b0;
  localparam logic WB_WE_WRITE = 1'b1;

  // Bits needed to hold a count ranging over 0..max_count inclusive.
  function automatic int count_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-depth response delay line with a synchronous flush that zeroes every stage.
module wb_resp_pipe #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 17
) (
  input  logic             clk_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] pre_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // pre_o is the value that will occupy the output stage after the next edge.
  generate
    if (DEPTH == 1) begin : g_pre_direct
      assign pre_o = d_i;
    end else begin : g_pre_stage
      assign pre_o = stage[DEPTH-2];
    end
  endgenerate

  assign q_o = stage[DEPTH-1];

endmodule

// File: rtl/wb_pipelined_slave.sv
// Wishbone B.4 pipelined slave: small byte-writable register file with fixed-latency,
// in-order acks and stall-based throttling of outstanding requests.
module wb_pipelined_slave
  import wb_pipelined_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WORDS_LOG2 = 4,
  parameter int LATENCY    = 2,
  parameter int MAX_OUTST  = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic                    stall_o,
  output logic                    ack_o,
  output logic [DATA_WIDTH-1:0]   dat_o
);

  localparam int NumWords = 1 << WORDS_LOG2;
  localparam int NumLanes = DATA_WIDTH / 8;
  localparam int OutstW   = count_width(MAX_OUTST);

  logic [DATA_WIDTH-1:0] mem [NumWords];
  logic [OutstW-1:0]     outst;
  logic [WORDS_LOG2-1:0] idx;
  logic                  accept;
  logic                  flush;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH:0]   pipe_d;
  logic [DATA_WIDTH:0]   pipe_pre;
  logic [DATA_WIDTH:0]   pipe_q;
  logic                  unused_adr;

  assign idx        = adr_i[WORDS_LOG2-1:0];
  assign unused_adr = ^adr_i;

  assign stall_o = reset_i | (outst == OutstW'(MAX_OUTST));
  assign accept  = cyc_i & stb_i & ~stall_o;
  assign flush   = reset_i | ~cyc_i;

  // Earlier writes have already landed in mem, so a read directly behind a write sees it.
  assign rd_data = (we_i == WB_WE_WRITE) ? '0 : mem[idx];
  assign pipe_d  = accept ? {1'b1, rd_data} : '0;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int w = 0; w < NumWords; w++) mem[w] <= '0;
    end else if (accept && (we_i == WB_WE_WRITE)) begin
      for (int b = 0; b < NumLanes; b++) begin
        if (sel_i[b]) mem[idx][b*8 +: 8] <= dat_i[b*8 +: 8];
      end
    end
  end

  wb_resp_pipe #(
    .DEPTH (LATENCY),
    .WIDTH (DATA_WIDTH + 1)
  ) u_resp_pipe (
    .clk_i   (clk_i),
    .flush_i (flush),
    .d_i     (pipe_d),
    .pre_o   (pipe_pre),
    .q_o     (pipe_q)
  );

  // A request stops counting once its response enters the output stage, so with
  // MAX_OUTST == LATENCY the stall lifts in time for one accept every cycle.
  always_ff @(posedge clk_i) begin
    if (flush) begin
      outst <= '0;
    end else begin
      outst <= outst + OutstW'(accept) - OutstW'(pipe_pre[DATA_WIDTH]);
    end
  end

  assign ack_o = pipe_q[DATA_WIDTH] & cyc_i & ~reset_i;
  assign dat_o = ack_o ? pipe_q[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_wb_pipelined_slave.sv
// Randomised check of two slave configurations (MAX_OUTST 2 and 1) against a
// queue-based model of fixed-latency acks, aborts, resets and byte-lane writes.
module tb_wb_pipelined_slave;

  localparam int L = 2;

  typedef struct {
    int          inst;
    int          due;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] adr = '0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [15:0] dat_w = '0;
  logic [1:0]  sel = '0;
  logic        stall_v [2];
  logic        ack_v [2];
  logic [15:0] dat_v [2];

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  exp_t        pend[$];
  logic [15:0] mmem [2][16];
  logic [15:0] last_rd [2];

  always #5 clk = ~clk;

  wb_pipelined_slave #(.LATENCY(L), .MAX_OUTST(2)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .adr_i(adr), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .dat_i(dat_w), .sel_i(sel), .stall_o(stall_v[0]), .ack_o(ack_v[0]), .dat_o(dat_v[0])
  );

  wb_pipelined_slave #(.LATENCY(L), .MAX_OUTST(1)) u_dut1 (
    .clk_i(clk), .reset_i(reset), .adr_i(adr), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .dat_i(dat_w), .sel_i(sel), .stall_o(stall_v[1]), .ack_o(ack_v[1]), .dat_o(dat_v[1])
  );

  function automatic int max_outst(input int inst);
    return (inst == 0) ? 2 : 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d got %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  // Drives one bus cycle, compares both DUTs against the model, then advances the model across the edge.
  task automatic applyStimulus(input logic r, input logic c, input logic s, input logic w,
                               input logic [15:0] a, input logic [15:0] d, input logic [1:0] sl);
    bit   acc [2];
    exp_t keep[$];
    reset = r; cyc = c; stb = s; we = w; adr = a; dat_w = d; sel = sl;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int          infl = 0;
      bit          e_ack = 0;
      bit          e_stall;
      logic [15:0] e_dat = '0;
      foreach (pend[k]) begin
        if (pend[k].inst == i) begin
          if (pend[k].due > cycle) infl++;
          if (pend[k].due == cycle) begin
            e_ack = 1;
            e_dat = pend[k].data;
          end
        end
      end
      e_stall = r || (infl >= max_outst(i));
      if (!c || r) e_ack = 0;
      if (!e_ack) e_dat = '0;
      checkOutput($sformatf("stall%0d", i), 32'(stall_v[i]), 32'(e_stall));
      checkOutput($sformatf("ack%0d", i), 32'(ack_v[i]), 32'(e_ack));
      checkOutput($sformatf("dat%0d", i), 32'(dat_v[i]), 32'(e_dat));
      if (ack_v[i]) last_rd[i] = dat_v[i];
      acc[i] = c && s && !e_stall;
    end
    keep = {};
    foreach (pend[k]) begin
      if (!r && c && pend[k].due > cycle) keep.push_back(pend[k]);
    end
    pend = keep;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        for (int m = 0; m < 16; m++) mmem[i][m] = '0;
      end else if (acc[i]) begin
        if (w) begin
          for (int b = 0; b < 2; b++) if (sl[b]) mmem[i][a[3:0]][b*8 +: 8] = d[b*8 +: 8];
          pend.push_back('{inst: i, due: cycle + L, data: 16'h0000});
        end else begin
          pend.push_back('{inst: i, due: cycle + L, data: mmem[i][a[3:0]]});
        end
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 1, 0, 0, 16'h0, 16'h0, 2'b00);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      last_rd[i] = '0;
      for (int m = 0; m < 16; m++) mmem[i][m] = '0;
    end
    @(posedge clk);
    #1;
    applyStimulus(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    applyStimulus(1, 0, 0, 0, 16'h0, 16'h0, 2'b00);
    idle(3);

    applyStimulus(0, 1, 1, 1, 16'd1, 16'hBEEF, 2'b11);
    applyStimulus(0, 1, 1, 0, 16'd1, 16'h0, 2'b00);
    idle(4);
    checkOutput("beef_rd0", 32'(last_rd[0]), 32'h0000BEEF);

    applyStimulus(0, 1, 1, 1, 16'd2, 16'h1234, 2'b11);
    idle(3);
    applyStimulus(0, 1, 1, 1, 16'd2, 16'hAB00, 2'b10);
    idle(3);
    applyStimulus(0, 1, 1, 0, 16'd2, 16'h0, 2'b00);
    idle(3);
    checkOutput("lane_rd0", 32'(last_rd[0]), 32'h0000AB34);
    applyStimulus(0, 1, 1, 0, 16'd18, 16'h0, 2'b00);
    idle(3);
    checkOutput("alias_rd0", 32'(last_rd[0]), 32'h0000AB34);
    checkOutput("alias_rd1", 32'(last_rd[1]), 32'h0000AB34);

    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 0, 16'(k), 16'h0, 2'b00);
    idle(4);

    applyStimulus(0, 1, 1, 0, 16'd1, 16'h0, 2'b00);
    applyStimulus(0, 1, 1, 0, 16'd2, 16'h0, 2'b00);
    applyStimulus(0, 0, 0, 0, 16'd0, 16'h0, 2'b00);
    idle(3);
    applyStimulus(0, 1, 1, 0, 16'd1, 16'h0, 2'b00);
    idle(3);

    applyStimulus(0, 1, 1, 0, 16'd1, 16'h0, 2'b00);
    applyStimulus(0, 1, 1, 0, 16'd2, 16'h0, 2'b00);
    applyStimulus(1, 1, 1, 0, 16'd1, 16'h0, 2'b00);
    applyStimulus(0, 1, 1, 0, 16'd1, 16'h0, 2'b00);
    idle(4);
    checkOutput("post_reset_rd0", 32'(last_rd[0]), 32'h00000000);

    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 99) < 2),
                    ($urandom_range(0, 99) < 90),
                    ($urandom_range(0, 99) < 70),
                    1'($urandom_range(0, 1)),
                    16'($urandom_range(0, 65535)),
                    16'($urandom_range(0, 65535)),
                    2'($urandom_range(0, 3)));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
